crc32_check: RTL and testbench

Receive-side CRC-32 checker. It is the counterpart of the crc32 generator block.
- Accepts one message word plus the CRC received with it, over a valid/ready handshake.
- Recomputes the CRC bit-serially, MSB first, one bit per clock.
- Reports the computed CRC and a match flag over a second valid/ready handshake.
- Keeps a saturating count of mismatches for link-health monitoring.

---
 rtl/crc32_check.sv | 160 ++++++++++++++++
 tb/tb_crc32_check.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_check.sv
// Receive-side CRC-32 checker: recomputes the CRC of a message word bit-serially,
// MSB first, and compares it against the CRC received with the message.
module crc32_check #(
    parameter int MSG_W = 32,
    parameter int ERR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [MSG_W-1:0]  message_i,
    input  logic [31:0]       crc_i,
    input  logic [31:0]       polynomial_i,
    input  logic              abort_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [31:0]       crc_calc_o,
    output logic              match_o,
    output logic [ERR_W-1:0]  err_count_o,
    input  logic              err_clr_i
);

    localparam int CNT_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MSG_W-1:0]   msg_sr_q, msg_sr_d;
    logic [31:0]        crc_q, crc_d;
    logic [31:0]        crc_rx_q, crc_rx_d;
    logic [31:0]        poly_q, poly_d;
    logic [31:0]        crc_out_q, crc_out_d;
    logic               match_q, match_d;
    logic               res_valid_q, res_valid_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               err_inc_s;

    // One step of the MSB-first LFSR: shift left, fold in the polynomial on feedback.
    function automatic logic [31:0] crc_step(
        input logic [31:0] crc,
        input logic        din,
        input logic [31:0] poly
    );
        logic fb;
        fb       = din ^ crc[31];
        crc_step = {crc[30:0], 1'b0} ^ (fb ? poly : 32'h0000_0000);
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            msg_sr_q    <= {MSG_W{1'b0}};
            crc_q       <= 32'h0000_0000;
            crc_rx_q    <= 32'h0000_0000;
            poly_q      <= 32'h0000_0000;
            crc_out_q   <= 32'h0000_0000;
            match_q     <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= {ERR_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            msg_sr_q    <= msg_sr_d;
            crc_q       <= crc_d;
            crc_rx_q    <= crc_rx_d;
            poly_q      <= poly_d;
            crc_out_q   <= crc_out_d;
            match_q     <= match_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
        end
    end

    // Next-state, shift datapath and result capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        msg_sr_d    = msg_sr_q;
        crc_d       = crc_q;
        crc_rx_d    = crc_rx_q;
        poly_d      = poly_q;
        crc_out_d   = crc_out_q;
        match_d     = match_q;
        res_valid_d = res_valid_q;
        err_inc_s   = 1'b0;

        case (state_q)
            IDLE: begin
                res_valid_d = 1'b0;
                if (in_valid_i) begin
                    msg_sr_d = message_i;
                    crc_rx_d = crc_i;
                    poly_d   = polynomial_i;
                    crc_d    = 32'h0000_0000;
                    cnt_d    = CNT_W'(MSG_W - 1);
                    state_d  = SHIFT;
                end else begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                // Abort wins over the final-shift transition; the last result stays visible.
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    crc_d    = crc_step(crc_q, msg_sr_q[MSG_W-1], poly_q);
                    msg_sr_d = {msg_sr_q[MSG_W-2:0], 1'b0};
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                // First DONE cycle loads the registered outputs; they then hold until taken.
                if (!res_valid_q) begin
                    res_valid_d = 1'b1;
                    crc_out_d   = crc_q;
                    match_d     = (crc_q == crc_rx_q);
                end else if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                    err_inc_s   = ~match_q;
                end else begin
                    state_d     = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // Saturating mismatch counter; clear beats a same-cycle increment.
    always_comb begin
        if (err_clr_i) begin
            err_d = {ERR_W{1'b0}};
        end else if (err_inc_s && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end else begin
            err_d = err_q;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign res_valid_o = res_valid_q;
    assign crc_calc_o  = crc_out_q;
    assign match_o     = match_q;
    assign err_count_o = err_q;

endmodule

// File: tb/tb_crc32_check.sv
// Directed bench for crc32_check: a 32-bit instance for the main scenarios and
// an 8-bit/ERR_W=4 instance for counter saturation and clear priority.
module tb_crc32_check;

    logic        clk;
    logic        rst;

    logic        a_in_valid, a_in_ready, a_abort, a_res_valid, a_res_ready, a_match, a_err_clr;
    logic [31:0] a_msg, a_crc, a_poly, a_calc;
    logic [15:0] a_err;

    logic        b_in_valid, b_in_ready, b_abort, b_res_valid, b_res_ready, b_match, b_err_clr;
    logic [7:0]  b_msg;
    logic [31:0] b_crc, b_poly, b_calc;
    logic [3:0]  b_err;

    int total = 0;
    int bad   = 0;

    crc32_check #(.MSG_W(32), .ERR_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .message_i(a_msg), .crc_i(a_crc), .polynomial_i(a_poly),
        .abort_i(a_abort),
        .res_valid_o(a_res_valid), .res_ready_i(a_res_ready),
        .crc_calc_o(a_calc), .match_o(a_match),
        .err_count_o(a_err), .err_clr_i(a_err_clr)
    );

    crc32_check #(.MSG_W(8), .ERR_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .message_i(b_msg), .crc_i(b_crc), .polynomial_i(b_poly),
        .abort_i(b_abort),
        .res_valid_o(b_res_valid), .res_ready_i(b_res_ready),
        .crc_calc_o(b_calc), .match_o(b_match),
        .err_count_o(b_err), .err_clr_i(b_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic a_send(input logic [31:0] m, input logic [31:0] c, input logic [31:0] p);
        a_in_valid = 1'b1; a_msg = m; a_crc = c; a_poly = p;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic a_wait(output int n);
        n = 0;
        while (!a_res_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic a_take();
        a_res_ready = 1'b1;
        @(posedge clk); #1;
        a_res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (a_res_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", a_res_valid); end
        total++; if (a_calc !== 32'h0) begin bad++; $display("FAIL rst_crc got=%h exp=00000000", a_calc); end
        total++; if (a_match !== 1'b0) begin bad++; $display("FAIL rst_match got=%b exp=0", a_match); end
        total++; if (a_err !== 16'h0) begin bad++; $display("FAIL rst_err got=%h exp=0000", a_err); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", a_in_ready); end
    endtask

    task automatic test_basic();
        int n;
        a_send(32'h0000_0001, 32'h04C1_1DB7, 32'h04C1_1DB7);
        a_wait(n);
        total++; if (n !== 33) begin bad++; $display("FAIL basic_latency got=%0d exp=33", n); end
        total++; if (a_calc !== 32'h04C1_1DB7) begin bad++; $display("FAIL basic_crc got=%h exp=04c11db7", a_calc); end
        total++; if (a_match !== 1'b1) begin bad++; $display("FAIL basic_match got=%b exp=1", a_match); end
        a_take();
        total++; if (a_err !== 16'h0) begin bad++; $display("FAIL basic_err got=%h exp=0000", a_err); end
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", a_in_ready); end
    endtask

    task automatic test_vectors();
        logic [31:0] m, c, p, e;
        int n;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       begin m = 32'h0000_0002; c = 32'h0982_3B6E; p = 32'h04C1_1DB7; e = 32'h0982_3B6E; end
                1:       begin m = 32'h0000_0003; c = 32'h0D43_26D9; p = 32'h04C1_1DB7; e = 32'h0D43_26D9; end
                2:       begin m = 32'h0000_0000; c = 32'h0000_0000; p = 32'h04C1_1DB7; e = 32'h0000_0000; end
                3:       begin m = 32'h0000_0100; c = 32'hD219_C1DC; p = 32'h04C1_1DB7; e = 32'hD219_C1DC; end
                default: begin m = 32'h0000_0001; c = 32'h1EDC_6F41; p = 32'h1EDC_6F41; e = 32'h1EDC_6F41; end
            endcase
            a_send(m, c, p);
            // Inputs changing after acceptance must not disturb the computation.
            a_msg = 32'hFFFF_FFFF; a_poly = 32'hFFFF_FFFF; a_crc = 32'h1234_5678;
            a_wait(n);
            total++; if (a_calc !== e) begin bad++; $display("FAIL vec%0d_crc got=%h exp=%h", i, a_calc, e); end
            total++; if (a_match !== 1'b1) begin bad++; $display("FAIL vec%0d_match got=%b exp=1", i, a_match); end
            a_take();
        end
        total++; if (a_err !== 16'h0) begin bad++; $display("FAIL vec_err got=%h exp=0000", a_err); end
    endtask

    task automatic test_mismatch();
        int n;
        a_send(32'h0000_0003, 32'h0D43_26D8, 32'h04C1_1DB7);
        a_wait(n);
        total++; if (a_calc !== 32'h0D43_26D9) begin bad++; $display("FAIL mis_crc got=%h exp=0d4326d9", a_calc); end
        total++; if (a_match !== 1'b0) begin bad++; $display("FAIL mis_match got=%b exp=0", a_match); end
        total++; if (a_err !== 16'h0) begin bad++; $display("FAIL mis_err_before got=%h exp=0000", a_err); end
        a_take();
        total++; if (a_err !== 16'h1) begin bad++; $display("FAIL mis_err_after got=%h exp=0001", a_err); end
    endtask

    task automatic test_backpressure();
        int n;
        a_send(32'h0000_0002, 32'h0982_3B6E, 32'h04C1_1DB7);
        a_wait(n);
        for (int k = 0; k < 10; k++) begin
            total++; if (a_res_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d got=%b exp=1", k, a_res_valid); end
            total++; if (a_calc !== 32'h0982_3B6E) begin bad++; $display("FAIL bp_crc%0d got=%h exp=09823b6e", k, a_calc); end
            total++; if (a_match !== 1'b1) begin bad++; $display("FAIL bp_match%0d got=%b exp=1", k, a_match); end
            total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d got=%b exp=0", k, a_in_ready); end
            a_in_valid = (k % 2 == 0); a_msg = 32'h0000_0003; a_crc = 32'h0; a_poly = 32'h04C1_1DB7;
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        a_take();
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after got=%b exp=1", a_in_ready); end
        total++; if (a_calc !== 32'h0982_3B6E) begin bad++; $display("FAIL bp_hold_crc got=%h exp=09823b6e", a_calc); end
        total++; if (a_err !== 16'h1) begin bad++; $display("FAIL bp_err got=%h exp=0001", a_err); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL bp_no_accept got=%b exp=1", a_in_ready); end
    endtask

    task automatic test_abort();
        int n;
        int seen;
        a_send(32'h0000_0001, 32'h0000_0000, 32'h04C1_1DB7);
        repeat (9) begin @(posedge clk); #1; end
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", a_in_ready); end
        total++; if (a_calc !== 32'h0982_3B6E) begin bad++; $display("FAIL abort_hold_crc got=%h exp=09823b6e", a_calc); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (a_res_valid) seen++;
            @(posedge clk); #1;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_result got=%0d exp=0", seen); end
        total++; if (a_err !== 16'h1) begin bad++; $display("FAIL abort_err got=%h exp=0001", a_err); end
        a_send(32'h0000_0004, 32'h1304_76DC, 32'h04C1_1DB7);
        a_wait(n);
        total++; if (n !== 33) begin bad++; $display("FAIL abort_next_latency got=%0d exp=33", n); end
        total++; if (a_calc !== 32'h1304_76DC) begin bad++; $display("FAIL abort_next_crc got=%h exp=130476dc", a_calc); end
        total++; if (a_match !== 1'b1) begin bad++; $display("FAIL abort_next_match got=%b exp=1", a_match); end
        a_take();
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        a_send(32'h0000_0003, 32'h0D43_26D9, 32'h04C1_1DB7);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        total++; if (a_calc !== 32'h0) begin bad++; $display("FAIL mrst_crc got=%h exp=00000000", a_calc); end
        total++; if (a_match !== 1'b0) begin bad++; $display("FAIL mrst_match got=%b exp=0", a_match); end
        total++; if (a_res_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%b exp=0", a_res_valid); end
        total++; if (a_err !== 16'h0) begin bad++; $display("FAIL mrst_err got=%h exp=0000", a_err); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL mrst_ready got=%b exp=1", a_in_ready); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (a_res_valid) seen++;
            @(posedge clk); #1;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL mrst_no_result got=%0d exp=0", seen); end
    endtask

    task automatic test_saturate();
        int n;
        logic [3:0] exp_err;
        for (int i = 1; i <= 17; i++) begin
            b_in_valid = 1'b1; b_msg = 8'h01; b_crc = 32'h0; b_poly = 32'h04C1_1DB7;
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            n = 0;
            while (!b_res_valid && n < 50) begin @(posedge clk); #1; n++; end
            if (i == 1) begin
                total++; if (n !== 9) begin bad++; $display("FAIL sat_latency got=%0d exp=9", n); end
                total++; if (b_calc !== 32'h04C1_1DB7) begin bad++; $display("FAIL sat_crc got=%h exp=04c11db7", b_calc); end
            end
            total++; if (b_match !== 1'b0) begin bad++; $display("FAIL sat_match%0d got=%b exp=0", i, b_match); end
            b_res_ready = 1'b1;
            @(posedge clk); #1;
            b_res_ready = 1'b0;
            exp_err = (i > 15) ? 4'hF : 4'(i);
            total++; if (b_err !== exp_err) begin bad++; $display("FAIL sat_err%0d got=%h exp=%h", i, b_err, exp_err); end
        end
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        n = 0;
        while (!b_res_valid && n < 50) begin @(posedge clk); #1; n++; end
        total++; if (b_res_valid !== 1'b1) begin bad++; $display("FAIL clr_valid got=%b exp=1", b_res_valid); end
        b_res_ready = 1'b1; b_err_clr = 1'b1;
        @(posedge clk); #1;
        b_res_ready = 1'b0; b_err_clr = 1'b0;
        total++; if (b_err !== 4'h0) begin bad++; $display("FAIL clr_err got=%h exp=0", b_err); end
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_abort = 1'b0; a_res_ready = 1'b0; a_err_clr = 1'b0;
        a_msg = 32'h0; a_crc = 32'h0; a_poly = 32'h0;
        b_in_valid = 1'b0; b_abort = 1'b0; b_res_ready = 1'b0; b_err_clr = 1'b0;
        b_msg = 8'h0; b_crc = 32'h0; b_poly = 32'h0;
        test_reset();
        test_basic();
        test_vectors();
        test_mismatch();
        test_backpressure();
        test_abort();
        test_reset_mid_shift();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
